divider_seq: RTL

//  Sequential signed divider; the inverse of the shift-add multiplier. A 2N-bit signed

---
 rtl/divider_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq -- sequential signed restoring divider
//
// Divides a 2N-bit signed dividend by an N-bit signed divisor. The quotient is
// truncated toward zero and the remainder takes the sign of the dividend, so
// dividend = quotient*divisor + remainder. The divider runs one restoring
// iteration per clock on operand magnitudes, then spends one cycle applying
// signs and saturating. Latency from a sampled start to ready is 2N+1 edges,
// independent of operand values.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, priority over start
//   start        loads operands and (re)starts a division at any time
//   dividend     2N-bit signed dividend
//   divisor      N-bit signed divisor
//   quotient     N-bit signed quotient, saturated on overflow or divide-by-zero
//   remainder    N-bit signed remainder
//   overflow     true quotient does not fit N bits signed
//   div_by_zero  divisor was zero
//   ready        high when idle or done; outputs are valid only while high
// -----------------------------------------------------------------------------
module divider_seq #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [2*N-1:0] dividend,
    input  logic signed [N-1:0]   divisor,
    output logic signed [N-1:0]   quotient,
    output logic signed [N-1:0]   remainder,
    output logic                  overflow,
    output logic                  div_by_zero,
    output logic                  ready
);

    localparam int CW = $clog2(2 * N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Largest quotient magnitudes representable for a positive / negative result.
    localparam logic [2*N-1:0] POS_LIM = (2*N)'((1 << (N - 1)) - 1);
    localparam logic [2*N-1:0] NEG_LIM = (2*N)'(1 << (N - 1));

    localparam logic signed [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic           sign_dvd;
    logic           sign_dsor;
    logic [N-1:0]   dsor_mag;
    // Dividend magnitude shifts out of the top while quotient bits shift in at
    // the bottom; after 2N iterations it holds the quotient magnitude.
    logic [2*N-1:0] dvd_sh;
    logic [N:0]     prem;

    // Operand magnitudes. Negating the most negative value wraps to the same
    // bit pattern, which is the correct unsigned magnitude.
    logic [2*N-1:0] dvd_abs;
    logic [N-1:0]   dsor_abs;

    // One restoring step, with one spare bit so the compare never truncates.
    logic [N+1:0]   prem_shift;
    logic [N+1:0]   dsor_ext;
    logic           q_bit;

    // Sign fix-up and saturation, consumed in FIX.
    logic           res_neg;
    logic           ovf_cond;
    logic [N-1:0]   rmag;
    logic signed [N-1:0] rem_signed;
    logic signed [N-1:0] quot_trunc;

    assign ready = (state == S_IDLE) || (state == S_DONE);

    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        dvd_abs    = dividend[2*N-1] ? (2*N)'(-dividend) : dividend;
        dsor_abs   = divisor[N-1]    ? N'(-divisor)      : divisor;

        prem_shift = {prem, dvd_sh[2*N-1]};
        dsor_ext   = {2'b00, dsor_mag};
        q_bit      = (prem_shift >= dsor_ext);

        res_neg    = sign_dvd ^ sign_dsor;
        ovf_cond   = res_neg ? (dvd_sh > NEG_LIM) : (dvd_sh > POS_LIM);
        rmag       = prem[N-1:0];
        rem_signed = sign_dvd ? N'(-rmag) : rmag;
        quot_trunc = res_neg ? N'(-dvd_sh[N-1:0]) : dvd_sh[N-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sign_dvd    <= 1'b0;
            sign_dsor   <= 1'b0;
            dsor_mag    <= '0;
            dvd_sh      <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            sign_dvd  <= dividend[2*N-1];
            sign_dsor <= divisor[N-1];
            dvd_sh    <= dvd_abs;
            dsor_mag  <= dsor_abs;
            prem      <= '0;
            cnt       <= '0;
            state     <= S_DIV;
        end else begin
            case (state)
                S_DIV: begin
                    dvd_sh <= {dvd_sh[2*N-2:0], q_bit};
                    prem   <= (N+1)'(q_bit ? (prem_shift - dsor_ext) : prem_shift);
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(2 * N - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dsor_mag == '0) begin
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        remainder   <= '0;
                        quotient    <= sign_dvd ? Q_MIN : Q_MAX;
                    end else if (ovf_cond) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                        remainder   <= rem_signed;
                        quotient    <= res_neg ? Q_MIN : Q_MAX;
                    end else begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        remainder   <= rem_signed;
                        quotient    <= quot_trunc;
                    end
                    state <= S_DONE;
                end
                default: begin
                    // IDLE and DONE hold everything until the next start.
                end
            endcase
        end
    end

endmodule
